// File: rtl/bin_to_bcd4_pkg.sv
// Shared constants and types for the bin_to_bcd4 binary-to-BCD converter.
package bin_to_bcd4_pkg;

  // Digit code that the seven-segment decoder shows as all segments off
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Number of BCD digits produced (thousands down to ones)
  localparam int BCD_DIGITS = 4;

  // Largest value that fits in four decimal digits
  localparam int MAX_VAL_DEFAULT = 9999;

  // Converter control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bin_to_bcd4_add3.sv
// Combinational double-dabble correction for one BCD digit.
// A digit of 5 or more gets 3 added so that the following left shift
// carries correctly into the next decimal digit.
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add 3 when the digit would overflow past 9 after doubling
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd4.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Handshake: start is sampled only while idle; busy stays high from the
// edge after start is accepted until the result edge; done pulses for
// exactly one cycle when dig_* and ovf update. start during busy or in
// the result cycle is dropped, never queued.
// Optional build macro BIN_TO_BCD4_LEADING_BLANK_EN replaces leading zero
// digits (above the ones digit) with the blank code.
module bin_to_bcd4
  import bin_to_bcd4_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = MAX_VAL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       dig_0,
  output logic [3:0]       dig_1,
  output logic [3:0]       dig_2,
  output logic [3:0]       dig_3
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  // Current state is kept as a named signal so checkers can bind to it
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   shreg;
  logic [15:0]        scratch;
  logic [15:0]        corr;
  logic               ovf_cap;
  logic [15:0]        result;

  // Parallel add-3 correction on all four scratch digits
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
    bcd_add3_digit u_add3 (
      .din  (scratch[4*i +: 4]),
      .dout (corr[4*i +: 4])
    );
  end

  // Final digit pattern: blanks on overflow, optional leading-zero blanking
  always_comb begin
    result = scratch;
    if (ovf_cap) begin
      result = {BCD_DIGITS{BCD_BLANK}};
    end
`ifdef BIN_TO_BCD4_LEADING_BLANK_EN
    else begin
      if (scratch[15:12] == 4'd0) result[15:12] = BCD_BLANK;
      if (scratch[15:8]  == 8'd0) result[11:8]  = BCD_BLANK;
      if (scratch[15:4]  == 12'd0) result[7:4]  = BCD_BLANK;
    end
`endif
  end

  // Control FSM, shift datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      scratch <= '0;
      ovf_cap <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      dig_0   <= 4'h0;
      dig_1   <= 4'h0;
      dig_2   <= 4'h0;
      dig_3   <= 4'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin_in;
            scratch <= '0;
            ovf_cap <= (32'(bin_in) > 32'(MAX_VAL));
            cnt     <= CNT_W'(BIN_W);
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          scratch <= {corr[14:0], shreg[BIN_W-1]};
          shreg   <= {shreg[BIN_W-2:0], 1'b0};
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          dig_0 <= result[3:0];
          dig_1 <= result[7:4];
          dig_2 <= result[11:8];
          dig_3 <= result[15:12];
          ovf   <= ovf_cap;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd4.sv
// Directed testbench for bin_to_bcd4 (default BIN_W=14).
module tb_bin_to_bcd4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  dig_0, dig_1, dig_2, dig_3;

  int n_cmp = 0;
  int n_err = 0;

  bin_to_bcd4 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .dig_0  (dig_0),
    .dig_1  (dig_1),
    .dig_2  (dig_2),
    .dig_3  (dig_3)
  );

  // Clock: 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {dig_3, dig_2, dig_1, dig_0};
  endfunction

  // Start a conversion at the current falling edge and check timing and result.
  // Start accepted at edge k: busy high for 15 sampled cycles, done seen at
  // the 16th falling edge after start was raised.
  task automatic conv(input string tag, input logic [13:0] v,
                      input logic [15:0] exp_d, input logic exp_ovf);
    int lat;
    int busy_cyc;
    start  = 1'b1;
    bin_in = v;
    lat = 0;
    busy_cyc = 0;
    while (lat < 40) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) busy_cyc++;
      if (done) break;
    end
    check({tag, "_latency"}, lat, 16);
    check({tag, "_busy_cycles"}, busy_cyc, 15);
    check({tag, "_digits"}, {16'h0, digits()}, {16'h0, exp_d});
    check({tag, "_ovf"}, {31'h0, ovf}, {31'h0, exp_ovf});
    @(negedge clk);
    check({tag, "_done_width"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    int lat;
    int ndone;
    logic blank;
`ifdef BIN_TO_BCD4_LEADING_BLANK_EN
    blank = 1'b1;
`else
    blank = 1'b0;
`endif
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_ovf", {31'h0, ovf}, 32'h0);
    check("reset_digits", {16'h0, digits()}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero, then a plain four-digit value
    conv("zero", 14'd0, blank ? 16'hFFF0 : 16'h0000, 1'b0);
    conv("v1234", 14'd1234, 16'h1234, 1'b0);

    // Back-to-back: start held high, bin_in changes after capture
    start  = 1'b1;
    bin_in = 14'd9999;
    @(negedge clk);
    bin_in = 14'd10000;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", lat, 16);
    check("b2b_first_digits", {16'h0, digits()}, 32'h9999);
    check("b2b_first_ovf", {31'h0, ovf}, 32'h0);
    @(negedge clk);
    check("b2b_restart_busy", {31'h0, busy}, 32'h1);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_second_latency", lat, 16);
    check("b2b_second_digits", {16'h0, digits()}, 32'hFFFF);
    check("b2b_second_ovf", {31'h0, ovf}, 32'h1);
    @(negedge clk);

    // Start pulsed mid-conversion with another value is ignored
    start  = 1'b1;
    bin_in = 14'd4321;
    ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 5) begin
        start  = 1'b1;
        bin_in = 14'd8765;
      end
      if (done) begin
        ndone++;
        check("midstart_digits", {16'h0, digits()}, 32'h4321);
        check("midstart_ovf", {31'h0, ovf}, 32'h0);
      end
    end
    start = 1'b0;
    check("midstart_done_count", ndone, 1);

    // Reset during conversion discards the partial result
    start  = 1'b1;
    bin_in = 14'd777;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_digits", {16'h0, digits()}, 32'h0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midreset_no_done", ndone, 0);
    conv("v56", 14'd56, blank ? 16'hFF56 : 16'h0056, 1'b0);

    // Leading-zero handling
    conv("v42", 14'd42, blank ? 16'hFF42 : 16'h0042, 1'b0);
    conv("v7001", 14'd7001, 16'h7001, 1'b0);
    conv("v305", 14'd305, blank ? 16'hF305 : 16'h0305, 1'b0);
    conv("v16383", 14'd16383, 16'hFFFF, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
